// File: rtl/alu_issue_stage.sv
// RV32I decode-to-execute issue stage: decodes the instruction into ALU operands/control
// plus branch/writeback sideband, held in one valid/ready ID/EX register with flush.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] operand_a,
    output logic [31:0] operand_b,
    output logic [3:0]  alu_control,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic        out_is_branch,
    output logic [2:0]  out_branch_f3,
    output logic        out_illegal
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0011;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b0101;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0111;
    localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b1000;
    localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b1001;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Instruction fields and immediates
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_u  = {in_instr[31:12], 12'b0};

    // Shared funct3 -> ALU op mapping for OP and OP-IMM; alt selects SUB/SRA
    function automatic logic [CTRL_W-1:0] f3_to_ctrl(input logic [2:0] f3, input logic alt);
        logic [CTRL_W-1:0] c;
        c = ALU_AND;
        case (f3)
            3'b000:  c = alt ? ALU_SUB : ALU_ADD;
            3'b001:  c = ALU_SLL;
            3'b010:  c = ALU_SLT;
            3'b011:  c = ALU_SLTU;
            3'b100:  c = ALU_XOR;
            3'b101:  c = alt ? ALU_SRA : ALU_SRL;
            3'b110:  c = ALU_OR;
            default: c = ALU_AND;
        endcase
        return c;
    endfunction

    logic [XLEN-1:0]   dec_a;
    logic [XLEN-1:0]   dec_b;
    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_wb;
    logic              dec_br;
    logic              dec_ill;
    logic              dec_rw;

    // Combinational decode of the incoming instruction
    always_comb begin
        dec_a    = '0;
        dec_b    = '0;
        dec_ctrl = ALU_ADD;
        dec_wb   = 1'b0;
        dec_br   = 1'b0;
        dec_ill  = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_a  = in_rs1_data;
                dec_b  = in_rs2_data;
                dec_wb = 1'b1;
                if (funct7 == F7_ZERO) begin
                    dec_ctrl = f3_to_ctrl(funct3, 1'b0);
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    dec_ctrl = f3_to_ctrl(funct3, 1'b1);
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_a    = in_rs1_data;
                dec_b    = imm_i;
                dec_wb   = 1'b1;
                dec_ctrl = f3_to_ctrl(funct3, 1'b0);
                if (funct3 == 3'b001 && funct7 != F7_ZERO) begin
                    dec_ill = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT) begin
                        dec_ctrl = ALU_SRA;
                    end else if (funct7 != F7_ZERO) begin
                        dec_ill = 1'b1;
                    end
                end
            end
            OPC_LUI: begin
                dec_b  = imm_u;
                dec_wb = 1'b1;
            end
            OPC_AUIPC: begin
                dec_a  = in_pc;
                dec_b  = imm_u;
                dec_wb = 1'b1;
            end
            OPC_LOAD: begin
                dec_a  = in_rs1_data;
                dec_b  = imm_i;
                dec_wb = 1'b1;
            end
            OPC_STORE: begin
                dec_a = in_rs1_data;
                dec_b = imm_s;
            end
            OPC_JAL, OPC_JALR: begin
                dec_a  = in_pc;
                dec_b  = XLEN'(4);
                dec_wb = 1'b1;
            end
            OPC_BRANCH: begin
                dec_a  = in_rs1_data;
                dec_b  = in_rs2_data;
                dec_br = 1'b1;
                case (funct3)
                    3'b000, 3'b001: dec_ctrl = ALU_SUB;
                    3'b100, 3'b101: dec_ctrl = ALU_SLT;
                    3'b110, 3'b111: dec_ctrl = ALU_SLTU;
                    default:        dec_ill  = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal encodings present a neutral op to the ALU
        if (dec_ill) begin
            dec_a    = '0;
            dec_b    = '0;
            dec_ctrl = ALU_AND;
            dec_wb   = 1'b0;
            dec_br   = 1'b0;
        end
    end

    assign dec_rw = dec_wb && (rd != 5'd0);

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [4:0]        rd_q;
    logic              rw_q;
    logic              br_q;
    logic [2:0]        f3_q;
    logic              ill_q;
    logic              accept;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Valid tracking: flush beats accept, accept beats drain
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            br_q    <= 1'b0;
            f3_q    <= '0;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                a_q    <= dec_a;
                b_q    <= dec_b;
                ctrl_q <= dec_ctrl;
                rd_q   <= rd;
                rw_q   <= dec_rw;
                br_q   <= dec_br;
                f3_q   <= funct3;
                ill_q  <= dec_ill;
            end
        end
    end

    assign out_valid     = valid_q;
    assign operand_a     = a_q;
    assign operand_b     = b_q;
    assign alu_control   = ctrl_q;
    assign out_rd        = rd_q;
    assign out_reg_write = rw_q;
    assign out_is_branch = br_q;
    assign out_branch_f3 = f3_q;
    assign out_illegal   = ill_q;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-to-execute issue stage for the RV32I core: takes a decoded-stage instruction with its PC and register-file read data, then produces the `operand_a` / `operand_b` / 4-bit `alu_control` triple consumed by the ALU, plus branch and writeback sideband. It holds everything in a single valid/ready-handshaked ID/EX pipeline register with flush support. There is one instance per core, sitting between the register-file read and the ALU.

## Interface
Parameters:
- none; datapath fixed at 32 bits

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  raw RV32I instruction word
- in_pc  in  32  instruction PC
- in_rs1_data  in  32  rs1 read data
- in_rs2_data  in  32  rs2 read data
- flush  in  1  discard held and incoming instruction (branch redirect)
- out_valid  out  1  output register holds a valid op
- out_ready  in  1  execute stage accepts this cycle
- operand_a  out  32  ALU operand A
- operand_b  out  32  ALU operand B
- alu_control  out  4  0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 XOR, 0101 SRL, 0110 SUB, 0111 SLT, 1000 SLTU, 1001 SRA
- out_rd  out  5  destination register
- out_reg_write  out  1  result written to rd (forced 0 when rd = 0)
- out_is_branch  out  1  conditional branch op
- out_branch_f3  out  3  branch funct3 (BEQ..BGEU)
- out_illegal  out  1  unsupported/malformed encoding

## Operation
- Decode by opcode, registered on accept:
  - OP (0110011): f3 000 → ADD (f7 0000000) or SUB (f7 0100000); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 → SRL (0000000) or SRA (0100000); 110 OR; 111 AND. a = rs1, b = rs2.
  - OP-IMM (0010011): same mapping; no SUB. b = sign-extended I-imm. f3 001 requires imm[11:5] = 0; f3 101 requires imm[11:5] ∈ {0000000, 0100000}.
  - LUI: a = 0, b = {imm[31:12], 12'b0}, ADD.
  - AUIPC: a = pc, b = U-imm, ADD.
  - LOAD: a = rs1, b = I-imm, ADD. STORE: a = rs1, b = S-imm, ADD, reg_write = 0.
  - JAL / JALR: a = pc, b = 4, ADD (link value).
  - BRANCH: a = rs1, b = rs2; BEQ/BNE → SUB; BLT/BGE → SLT; BLTU/BGEU → SLTU. is_branch = 1, reg_write = 0, f3 passed through; f3 010/011 illegal.
- Any other opcode, or an illegal f7/f3 combination: out_illegal = 1, alu_control = 0000, operands 0, reg_write = 0, is_branch = 0.

## Timing
- Reset (async assert, sync-released use): out_valid = 0; all other outputs 0.
- in_ready = !out_valid || out_ready (combinational; no bubble at full throughput).
- Accept when in_valid && in_ready && !flush: output register loads next edge, out_valid = 1. Latency 1 cycle.
- out_valid && !out_ready: all outputs held stable, in_ready = 0.
- out_valid && out_ready && !in_valid: out_valid → 0 next edge.
- flush: out_valid → 0 next edge regardless of out_ready/in_valid; incoming instruction dropped. Flush has priority over accept.
- Reset mid-transfer: held op discarded immediately; no output until a new accept.

## Test plan
- Reset: assert rst_n = 0 with out_valid = 1 → out_valid and all outputs 0 asynchronously; in_ready = 1 after release.
- ADD/SUB/SRA: `add x3,x1,x2` (0x002081B3), rs1 = 5, rs2 = 7 → next cycle a = 5, b = 7, alu_control = 0010, rd = 3, reg_write = 1; `sub` (0x402081B3) → 0110; `srai x3,x1,4` (0x4040D193) → 1001, b = 0x404.
- Branch: `blt x1,x2` (0x0020C463), rs1 = 0xFFFFFFFF, rs2 = 1 → alu_control = 0111, is_branch = 1, f3 = 100, reg_write = 0.
- Backpressure: 3 back-to-back valid ops with out_ready low for 2 cycles mid-stream → outputs stable while stalled, in_ready = 0, no op lost or duplicated, order preserved.
- Flush: flush = 1 while out_valid = 1 and in_valid = 1 → out_valid = 0 next cycle, neither op appears.
- Illegal: instr 0x0000007F, or OP with f7 = 0000001 → out_illegal = 1, alu_control = 0000, reg_write = 0; `addi x0,x0,1` → reg_write = 0.
